key_scan: RTL and testbench
===========================

# key_scan

Keypad front end for the tic-tac-toe board. It scans a 4x3 matrix keypad, debounces the scan, and emits one single-cycle key event per clean press. The event carries a 4-bit cell code that the game-state stage uses to mark `board`. The block sits directly upstream of the game-state logic and is the only source of `key_data`.

## Interface
Parameters:
- `SCAN_DIV`, default 25000: clocks per row dwell. Minimum 4.
- `DEBOUNCE_SCANS`, default 4: extra identical full-scan snapshots required before the debounced state updates. Minimum 1.

Ports:
- `clk` input 1: system clock. This is the block's only clock.
- `rst` input 1: reset. Synchronous and active-high.
- `key_col` input 3: column sense lines, active-low, asynchronous to `clk`.
- `key_row` output 4: row drive, active-low, exactly one bit low at a time.
- `key_data` output 4: code of the last emitted key.
- `key_valid` output 1: one-clock event strobe.
- `key_held` output 1: high while the FSM is in HELD.

## Operation
- **Column synchronizer:** `key_col` passes through a 2-flop synchronizer before any use.
- **Row scan:**
  - A dwell counter counts 0..SCAN_DIV-1.
  - On wrap, the row index advances 0→1→2→3→0.
  - `key_row` is registered. Row r drives bit r low.
- **Sampling:**
  - On the last dwell cycle of row r, the synchronized columns (inverted, so 1 = pressed) are written into a 12-bit working snapshot at bits [3r+2:3r].
  - The row-3 sample completes a snapshot.
- **Key map:** column c of row r is key index 3r+c. Codes are:
  - rows 0–2: 1,2,3 / 4,5,6 / 7,8,9
  - row 3: `*`=10, `0`=0, `#`=11
- **Debounce, on each completed snapshot:**
  - If it equals the previous snapshot, the stable counter increments, saturating at DEBOUNCE_SCANS.
  - Otherwise the counter clears and the previous snapshot is replaced.
  - When the counter reaches DEBOUNCE_SCANS, the debounced 12-bit state is loaded with the snapshot.
- **FSM, evaluated on each debounced-state load:**
  - **RELEASED:**
    - Exactly one key pressed (eligible): pulse `key_valid`, load `key_data`, go to HELD.
    - Two or more keys pressed: go to HELD with no pulse (ghost lockout).
    - No keys pressed: stay in RELEASED.
  - **HELD:** leave for RELEASED only when the debounced state is all released. Any other change, including a different single key, produces no event.
- `key_data` holds its value between events. Downstream logic acts only on `key_valid`.

## Timing
- **Reset values, applied on a `rst` edge at any time:**
  - `key_row`=4'b1110, `key_data`=0, `key_valid`=0, `key_held`=0
  - dwell counter, row index, stable counter = 0
  - snapshots and debounced state all released; FSM in RELEASED
- **Full scan period:** 4·SCAN_DIV clocks.
- **Debounce latency:** DEBOUNCE_SCANS+1 consecutive identical snapshots are needed for a state change.
- **`key_valid` timing:** high for exactly one clock, on the cycle after the row-3 sample edge that completes the qualifying snapshot. `key_data` updates on that same edge.
- **Settling:** column settling per row is SCAN_DIV-3 clocks after the synchronizer delay.
- **Reset mid-operation:** any in-progress debounce is discarded. A key still held after reset is a new press and emits once after debounce.
- **Simultaneous events:** a press and release landing in the same snapshot compare as a change, so debounce restarts. Only debounced transitions count.

## Configuration
- `KEYSCAN_CELL_ONLY_EN` defined: only codes 1..9 are eligible. A lone `*`, `0` or `#` moves the FSM to HELD with no `key_valid`; `key_data` is unchanged.
- Undefined: all twelve codes are eligible and are emitted per the key map.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-clock scan).
- **Reset:** assert `rst` for 3 clocks with all columns high → `key_row`=1110, `key_data`=0, `key_valid`=0, `key_held`=0. `key_row` steps 1101, 1011, 0111 at 4-clock intervals.
- **Clean press:** hold key 5 (row1/col1) for 10 scans → exactly one `key_valid`, after the 3rd identical snapshot, with `key_data`=5. `key_held`=1 until 3 identical released snapshots follow release.
- **Bounce:** key 7 alternating pressed/released every scan for 5 scans, then held steady → no pulse during bouncing; exactly one pulse, `key_data`=7, after 3 steady snapshots.
- **Ghost lockout:** keys 1 and 9 together → no pulse, `key_held`=1. Release 9 with 1 still held → no pulse. Release all, then press 3 → one pulse, `key_data`=3.
- **Configuration:** press `*` → with `KEYSCAN_CELL_ONLY_EN` undefined, pulse with `key_data`=10. With it defined, no pulse, `key_held`=1, `key_data` keeps its prior value.
- **Reset mid-hold:** hold 2 until HELD, pulse `rst` for 1 clock → all outputs return to reset values. One new pulse with `key_data`=2 follows 3 identical snapshots.

Source files
------------

// File: rtl/key_scan.sv
// key_scan: 4x3 matrix keypad scanner with snapshot debounce and single-press event FSM.
// Define KEYSCAN_CELL_ONLY_EN to restrict events to the board cell keys 1..9.
module key_scan #(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_col,
  output logic [3:0] key_row,
  output logic [3:0] key_data,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic {
    RELEASED,
    HELD
  } state_t;

  logic [2:0]    col_meta;
  logic [2:0]    col_sync;
  logic [DW-1:0] dwell;
  logic [1:0]    row_idx;
  logic [8:0]    work;
  logic [11:0]   prev_snap;
  logic [11:0]   stable_state;
  logic [SW-1:0] stable_cnt;
  state_t        state;

  logic          last_dwell;
  logic          snap_done;
  logic [11:0]   snap;
  logic [SW-1:0] next_cnt;
  logic          load;
  logic [11:0]   deb_next;
  logic          single;
  logic          any_pressed;
  logic [3:0]    key_idx;
  logic [3:0]    key_code;
  logic          eligible;

  // Column lines come straight off the keypad, so they are synchronized first.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta <= 3'b111;
      col_sync <= 3'b111;
    end else begin
      col_meta <= key_col;
      col_sync <= col_meta;
    end
  end

  assign last_dwell = (dwell == DW'(SCAN_DIV - 1));
  assign snap_done  = last_dwell && (row_idx == 2'd3);
  assign snap       = {~col_sync, work};

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell   <= '0;
      row_idx <= 2'd0;
      key_row <= 4'b1110;
      work    <= '0;
    end else if (last_dwell) begin
      dwell   <= '0;
      row_idx <= row_idx + 2'd1;
      key_row <= ~(4'b0001 << (row_idx + 2'd1));
      case (row_idx)
        2'd0: work[2:0] <= ~col_sync;
        2'd1: work[5:3] <= ~col_sync;
        2'd2: work[8:6] <= ~col_sync;
        default: work <= work;
      endcase
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  always_comb begin
    next_cnt = '0;
    if (snap == prev_snap) begin
      if (stable_cnt == SW'(DEBOUNCE_SCANS)) next_cnt = stable_cnt;
      else next_cnt = stable_cnt + SW'(1);
    end
  end

  assign load     = snap_done && (next_cnt == SW'(DEBOUNCE_SCANS));
  assign deb_next = load ? snap : stable_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_snap    <= '0;
      stable_cnt   <= '0;
      stable_state <= '0;
    end else if (snap_done) begin
      prev_snap    <= snap;
      stable_cnt   <= next_cnt;
      stable_state <= deb_next;
    end
  end

  // Decode the debounced state: lone-key detection and key index/code lookup.
  always_comb begin
    key_idx = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (deb_next[i]) key_idx = 4'(i);
    end
  end

  assign any_pressed = |deb_next;
  assign single      = any_pressed && ((deb_next & (deb_next - 12'd1)) == 12'd0);

  always_comb begin
    case (key_idx)
      4'd9:    key_code = 4'd10;
      4'd10:   key_code = 4'd0;
      4'd11:   key_code = 4'd11;
      default: key_code = key_idx + 4'd1;
    endcase
  end

`ifdef KEYSCAN_CELL_ONLY_EN
  assign eligible = single && (key_idx < 4'd9);
`else
  assign eligible = single;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RELEASED;
      key_valid <= 1'b0;
      key_data  <= 4'd0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (load) begin
        case (state)
          RELEASED: begin
            if (eligible) begin
              key_valid <= 1'b1;
              key_data  <= key_code;
            end
            if (any_pressed) begin
              state    <= HELD;
              key_held <= 1'b1;
            end
          end
          HELD: begin
            if (!any_pressed) begin
              state    <= RELEASED;
              key_held <= 1'b0;
            end
          end
          default: state <= RELEASED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_scan.sv
// Self-checking bench for key_scan: keypad model, per-scan reference model, directed plan plus random presses.
module tb_key_scan;

  localparam int SD  = 4;
  localparam int DEB = 2;

  logic        clk;
  logic        rst;
  logic [2:0]  key_col;
  logic [3:0]  key_row;
  logic [3:0]  key_data;
  logic        key_valid;
  logic        key_held;

  logic [11:0] pressed;

  int compared;
  int mismatched;
  int pulses;

  // Reference model state: last snapshot, length of identical run, held flag, last code.
  logic [11:0] mLast;
  int          mRun;
  bit          mHeld;
  int          mData;

  int codeMap [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

  key_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_col   (key_col),
    .key_row   (key_row),
    .key_data  (key_data),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its column low while its row is driven low.
  always_comb begin
    key_col = 3'b111;
    for (int r = 0; r < 4; r++) begin
      if (key_row == ~(4'b0001 << r)) begin
        for (int c = 0; c < 3; c++) begin
          if (pressed[3*r+c]) key_col[c] = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mLast = '0;
    mRun  = 1;
    mHeld = 0;
    mData = 0;
  endtask

  task automatic modelScan(input logic [11:0] s, output bit pulse);
    int n;
    int idx;
    bit ok;
    pulse = 0;
    if (s == mLast) mRun++;
    else begin
      mLast = s;
      mRun  = 1;
    end
    if (mRun >= DEB + 1) begin
      n   = $countones(s);
      idx = 0;
      for (int i = 0; i < 12; i++) if (s[i]) idx = i;
      if (!mHeld) begin
        if (n == 1) begin
          ok = 1;
`ifdef KEYSCAN_CELL_ONLY_EN
          ok = (idx < 9);
`endif
          if (ok) begin
            pulse = 1;
            mData = codeMap[idx];
          end
        end
        if (n >= 1) mHeld = 1;
      end else if (n == 0) begin
        mHeld = 0;
      end
    end
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
    modelReset();
    checkOutput("reset key_row", int'(key_row), 14);
    checkOutput("reset key_data", int'(key_data), 0);
    checkOutput("reset key_valid", int'(key_valid), 0);
    checkOutput("reset key_held", int'(key_held), 0);
  endtask

  // One full scan with a fixed set of pressed keys, checked every clock.
  task automatic applyStimulus(input logic [11:0] keys);
    bit expPulse;
    bit prevHeld;
    int prevData;
    int row;
    pressed  = keys;
    prevHeld = mHeld;
    prevData = mData;
    modelScan(keys, expPulse);
    for (int n = 1; n <= 4 * SD; n++) begin
      @(posedge clk);
      #1;
      row = (n / SD) % 4;
      checkOutput("key_row step", int'(key_row), int'(~(4'b0001 << row) & 4'hF));
      if (n < 4 * SD) begin
        checkOutput("key_valid idle", int'(key_valid), 0);
        checkOutput("key_held mid-scan", int'(key_held), int'(prevHeld));
        checkOutput("key_data hold", int'(key_data), prevData);
      end else begin
        checkOutput("key_valid event", int'(key_valid), int'(expPulse));
        checkOutput("key_held scan end", int'(key_held), int'(mHeld));
        checkOutput("key_data scan end", int'(key_data), mData);
      end
      if (key_valid) pulses++;
    end
  endtask

  task automatic scans(input logic [11:0] keys, input int count);
    for (int i = 0; i < count; i++) applyStimulus(keys);
  endtask

  initial begin
    logic [11:0] cur;
    int sel;
    compared   = 0;
    mismatched = 0;
    pulses     = 0;
    rst        = 1'b1;
    pressed    = '0;
    modelReset();
    @(posedge clk);
    #1;

    doReset(3);
    scans(12'h000, 2);

    // Clean press of key 5 (row 1, col 1)
    pulses = 0;
    scans(12'h010, 10);
    checkOutput("clean press pulses", pulses, 1);
    checkOutput("clean press data", int'(key_data), 5);
    checkOutput("clean press held", int'(key_held), 1);
    scans(12'h000, 2);
    checkOutput("release pending held", int'(key_held), 1);
    scans(12'h000, 1);
    checkOutput("release done held", int'(key_held), 0);

    // Bouncing key 7 then steady
    pulses = 0;
    for (int i = 0; i < 5; i++) applyStimulus((i % 2 == 0) ? 12'h040 : 12'h000);
    checkOutput("bounce pulses", pulses, 0);
    scans(12'h040, 3);
    checkOutput("bounce settle pulses", pulses, 1);
    checkOutput("bounce data", int'(key_data), 7);
    scans(12'h000, 3);

    // Ghost lockout: keys 1 and 9, then 1 alone, then 3
    pulses = 0;
    scans(12'h101, 4);
    checkOutput("ghost pulses", pulses, 0);
    checkOutput("ghost held", int'(key_held), 1);
    scans(12'h001, 4);
    checkOutput("ghost partial pulses", pulses, 0);
    scans(12'h000, 3);
    scans(12'h004, 4);
    checkOutput("after ghost pulses", pulses, 1);
    checkOutput("after ghost data", int'(key_data), 3);
    scans(12'h000, 3);

    // Star key
    pulses = 0;
    scans(12'h200, 4);
    checkOutput("star held", int'(key_held), 1);
`ifdef KEYSCAN_CELL_ONLY_EN
    checkOutput("star pulses", pulses, 0);
    checkOutput("star data kept", int'(key_data), 3);
`else
    checkOutput("star pulses", pulses, 1);
    checkOutput("star data", int'(key_data), 10);
`endif
    scans(12'h000, 3);

    // Reset while key 2 is held
    scans(12'h002, 3);
    checkOutput("pre-reset held", int'(key_held), 1);
    doReset(1);
    pulses = 0;
    scans(12'h002, 4);
    checkOutput("post-reset pulses", pulses, 1);
    checkOutput("post-reset data", int'(key_data), 2);
    scans(12'h000, 3);

    // Random press patterns against the model
    cur = '0;
    for (int i = 0; i < 120; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel >= 4 && sel <= 5) cur = '0;
      else if (sel >= 6 && sel <= 8) cur = 12'(1) << $urandom_range(0, 11);
      else if (sel == 9) cur = (12'(1) << $urandom_range(0, 11)) | (12'(1) << $urandom_range(0, 11));
      applyStimulus(cur);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
